// File: rtl/jamma_input_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : jamma_input_scanner
//  Description : Time-multiplexed JAMMA control scanner. Steps the external
//                splitter select through NUM_PLAYERS players. For each player
//                it waits SETTLE_CYC cycles, then samples the shared
//                active-low JJOY bus. Each bit is debounced per player. Raw
//                coin lines are synchronised and then stretched to a minimum
//                low width.
//  Ports       : clk_i          system/pixel clock
//                rst_ni         async active-low reset (release is expected
//                               to be synchronous to clk_i)
//                en_i           scan enable; low freezes scan + debounce
//                jjoy_i         shared joystick bus, active low
//                local_joy_i    on-board joystick, ANDed into player 0
//                jcoin_i        raw coin inputs, active low, asynchronous
//                jselect_o      splitter select = current player index
//                joy_out_o      debounced words, player p at [p*JOY_W +: JOY_W]
//                coin_out_o     stretched coin outputs, active low
//                frame_done_o   1-cycle pulse after the last player's sample
//  Revision    : 1.0  initial release
// ============================================================================
module jamma_input_scanner #(
    parameter int NUM_PLAYERS  = 2,
    parameter int JOY_W        = 8,
    parameter int SEL_W        = 2,
    parameter int SETTLE_CYC   = 2,
    parameter int DEBOUNCE_LEN = 3,
    parameter int COIN_MIN_CYC = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic [JOY_W-1:0]             jjoy_i,
    input  logic [JOY_W-1:0]             local_joy_i,
    input  logic [NUM_PLAYERS-1:0]       jcoin_i,
    output logic [SEL_W-1:0]             jselect_o,
    output logic [NUM_PLAYERS*JOY_W-1:0] joy_out_o,
    output logic [NUM_PLAYERS-1:0]       coin_out_o,
    output logic                         frame_done_o
);

    localparam int SC_W = $clog2(SETTLE_CYC + 1);
    localparam int DB_W = $clog2(DEBOUNCE_LEN + 1);
    localparam int CN_W = $clog2(COIN_MIN_CYC + 1);
    localparam int NB   = NUM_PLAYERS * JOY_W;

    localparam logic [SEL_W-1:0] LAST_P = SEL_W'(NUM_PLAYERS - 1);

    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_SAMPLE = 1'b1;

    // ------------------------------------------------------------------
    // Scan FSM state
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [SEL_W-1:0] player_q, player_d;
    logic             frame_done_q, frame_done_d;

    // Debounce state: one output bit and one counter per player per bit
    logic [NB-1:0]            joy_q, joy_d;
    logic [NB-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

    // Coin path: 2-FF synchroniser plus one delayed copy for edge detection
    logic [NUM_PLAYERS-1:0]            sync1_q, sync2_q, sync3_q;
    logic [NUM_PLAYERS-1:0][CN_W-1:0]  coin_cnt_q, coin_cnt_d;
    logic [NUM_PLAYERS-1:0]            coin_q, coin_d;

    logic [JOY_W-1:0] w_sample;
    logic             w_do_sample;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            player_q     <= '0;
            frame_done_q <= 1'b0;
            joy_q        <= '1;
            db_cnt_q     <= '0;
            sync1_q      <= '1;
            sync2_q      <= '1;
            sync3_q      <= '1;
            coin_cnt_q   <= '0;
            coin_q       <= '1;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            player_q     <= player_d;
            frame_done_q <= frame_done_d;
            joy_q        <= joy_d;
            db_cnt_q     <= db_cnt_d;
            sync1_q      <= jcoin_i;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            coin_cnt_q   <= coin_cnt_d;
            coin_q       <= coin_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic for the scan FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        player_d     = player_q;
        frame_done_d = 1'b0;
        if (en_i) begin
            case (state_q)
                ST_SETTLE: begin
                    // Counter runs 0..SETTLE_CYC-1, i.e. SETTLE_CYC cycles
                    if (settle_cnt_q == SC_W'(SETTLE_CYC - 1)) begin
                        settle_cnt_d = '0;
                        state_d      = ST_SAMPLE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SC_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    state_d      = ST_SETTLE;
                    frame_done_d = (player_q == LAST_P);
                    player_d     = (player_q == LAST_P) ? '0 : player_q + SEL_W'(1);
                end
                default: state_d = ST_SETTLE;
            endcase
        end
    end

    // Player 0 also sees the on-board joystick (active low, so AND merges)
    assign w_sample    = jjoy_i & ((player_q == '0) ? local_joy_i : '1);
    assign w_do_sample = en_i && (state_q == ST_SAMPLE);

    // ------------------------------------------------------------------
    // Debounce: only the word of the player being sampled moves
    // ------------------------------------------------------------------
    always_comb begin
        joy_d    = joy_q;
        db_cnt_d = db_cnt_q;
        if (w_do_sample) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (player_q == SEL_W'(p)) begin
                    for (int b = 0; b < JOY_W; b++) begin
                        if (w_sample[b] == joy_q[p*JOY_W + b]) begin
                            // Agreement (or a glitch returning) restarts the count
                            db_cnt_d[p*JOY_W + b] = '0;
                        end else if (db_cnt_q[p*JOY_W + b] == DB_W'(DEBOUNCE_LEN - 1)) begin
                            joy_d[p*JOY_W + b]    = w_sample[b];
                            db_cnt_d[p*JOY_W + b] = '0;
                        end else begin
                            db_cnt_d[p*JOY_W + b] = db_cnt_q[p*JOY_W + b] + DB_W'(1);
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Coin stretch, independent of en_i. The falling edge cycle itself is
    // the first low cycle (sync2 is already low), so the counter is loaded
    // with COIN_MIN_CYC-1 for a total low width of COIN_MIN_CYC. A busy
    // counter ignores further edges.
    // ------------------------------------------------------------------
    always_comb begin
        coin_cnt_d = coin_cnt_q;
        coin_d     = '1;
        for (int c = 0; c < NUM_PLAYERS; c++) begin
            if (coin_cnt_q[c] != '0) begin
                coin_cnt_d[c] = coin_cnt_q[c] - CN_W'(1);
            end else if (sync3_q[c] && !sync2_q[c]) begin
                coin_cnt_d[c] = CN_W'(COIN_MIN_CYC - 1);
            end
            coin_d[c] = sync2_q[c] && (coin_cnt_q[c] == '0);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        jselect_o    = player_q;
        frame_done_o = frame_done_q;
        joy_out_o    = joy_q;
        coin_out_o   = coin_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_jamma_input_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jamma_input_scanner
//  Description : Self-checking bench for jamma_input_scanner (2 players,
//                8-bit words, settle 2, debounce 3, coin stretch 64).
//                One table row = one scan frame of joystick stimulus with
//                expected debounced words; hand-written sequences cover the
//                select cadence, enable freeze, mid-frame reset and coins.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jamma_input_scanner;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  jjoy;
    logic [7:0]  local_joy;
    logic [1:0]  jcoin;
    logic [1:0]  jselect;
    logic [15:0] joy_out;
    logic [1:0]  coin_out;
    logic        frame_done;

    logic [7:0]  cur_p0;
    logic [7:0]  cur_p1;

    int n_chk;
    int n_pass;

    typedef struct {
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] loc;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t tbl [14];

    jamma_input_scanner #(
        .NUM_PLAYERS  (2),
        .JOY_W        (8),
        .SEL_W        (2),
        .SETTLE_CYC   (2),
        .DEBOUNCE_LEN (3),
        .COIN_MIN_CYC (64)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .jjoy_i       (jjoy),
        .local_joy_i  (local_joy),
        .jcoin_i      (jcoin),
        .jselect_o    (jselect),
        .joy_out_o    (joy_out),
        .coin_out_o   (coin_out),
        .frame_done_o (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The external splitter: the bus shows whichever player is selected
    always_comb jjoy = (jselect == 2'd0) ? cur_p0 : cur_p1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance to the next negedge at which frame_done is high (bounded)
    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 20);
        check("frame_done_timeout", 32'(frame_done), 32'd1);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;

        //        p0     p1     loc    exp p0 exp p1
        tbl[0]  = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[1]  = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[2]  = '{8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'hFF}; // 3rd sample updates
        tbl[3]  = '{8'hFE, 8'hFE, 8'hFF, 8'hFE, 8'hFF}; // p1 one-frame glitch
        tbl[4]  = '{8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'hFF};
        tbl[5]  = '{8'hFE, 8'hFE, 8'hFF, 8'hFE, 8'hFF};
        tbl[6]  = '{8'hFE, 8'hFE, 8'hFF, 8'hFE, 8'hFF}; // count restarted at 0
        tbl[7]  = '{8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'hFF};
        tbl[8]  = '{8'hFF, 8'hFF, 8'hEF, 8'hFE, 8'hFF}; // local joystick
        tbl[9]  = '{8'hFF, 8'hFF, 8'hEF, 8'hFE, 8'hFF};
        tbl[10] = '{8'hFF, 8'hFF, 8'hEF, 8'hEF, 8'hFF};
        tbl[11] = '{8'hFF, 8'h0F, 8'hFF, 8'hEF, 8'hFF};
        tbl[12] = '{8'hFF, 8'h0F, 8'hFF, 8'hEF, 8'hFF};
        tbl[13] = '{8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h0F};

        rst_n     = 1'b0;
        en        = 1'b0;
        local_joy = 8'hFF;
        jcoin     = 2'b11;
        cur_p0    = 8'hFF;
        cur_p1    = 8'hFF;

        repeat (3) @(negedge clk);
        check("rst_jselect",    32'(jselect),    32'd0);
        check("rst_joy_out",    32'(joy_out),    32'hFFFF);
        check("rst_coin_out",   32'(coin_out),   32'h3);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // Select cadence 0,0,0,1,1,1,... with frame_done every 6 cycles
        rst_n = 1'b1;
        en    = 1'b1;
        for (int c = 0; c < 14; c++) begin
            check($sformatf("seq_jselect_c%0d", c), 32'(jselect), 32'((c / 3) % 2));
            check($sformatf("seq_fd_c%0d", c), 32'(frame_done),
                  32'((c % 6 == 0) && (c != 0)));
            @(negedge clk);
        end

        // Debounce table: each row applied for exactly one frame
        wait_fd();
        for (int i = 0; i < 14; i++) begin
            cur_p0    = tbl[i].p0;
            cur_p1    = tbl[i].p1;
            local_joy = tbl[i].loc;
            wait_fd();
            check($sformatf("vec%0d_p0", i), 32'(joy_out[7:0]),  32'(tbl[i].e0));
            check($sformatf("vec%0d_p1", i), 32'(joy_out[15:8]), 32'(tbl[i].e1));
        end

        // Enable freeze in the middle of player 0's settle
        @(negedge clk);
        en     = 1'b0;
        cur_p0 = 8'h00;
        cur_p1 = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("frz_jselect_%0d", i), 32'(jselect),    32'd0);
            check($sformatf("frz_fd_%0d", i),      32'(frame_done), 32'd0);
            check($sformatf("frz_joy_%0d", i),     32'(joy_out),    32'h0FFF);
        end
        cur_p0 = 8'hFF;
        cur_p1 = 8'h0F;
        en     = 1'b1;
        // Resumes at frame cycle 1: frame_done lands 5 cycles later
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("resume_fd_%0d", k), 32'(frame_done), 32'(k == 5));
            check($sformatf("resume_jselect_%0d", k), 32'(jselect),
                  32'((k + 1 >= 3) && (k + 1 <= 5)));
        end

        // Reset asserted while player 1 is selected
        repeat (3) @(negedge clk);
        check("pre_rst_jselect", 32'(jselect), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_jselect",    32'(jselect),    32'd0);
        check("mid_rst_joy_out",    32'(joy_out),    32'hFFFF);
        check("mid_rst_coin_out",   32'(coin_out),   32'h3);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Coin: 2-cycle low pulse, second pulse 30 cycles into the stretch
        for (int k = 0; k < 76; k++) begin
            if (k == 0 || k == 33) jcoin[0] = 1'b0;
            if (k == 2 || k == 35) jcoin[0] = 1'b1;
            #1;
            check($sformatf("coin_k%0d", k), 32'(coin_out),
                  32'({1'b1, !((k >= 3) && (k <= 66))}));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
